// File: rtl/addsub_pkg.sv
// Shared constants for the 4-bit adder/subtractor lab: entry-step codes
// (also used by the display top for prompts) and operation codes.
package addsub_pkg;

  // Entry step, exposed directly on the step output.
  typedef enum logic [1:0] {
    S_GET_X  = 2'd0,
    S_GET_Y  = 2'd1,
    S_GET_OP = 2'd2,
    S_DONE   = 2'd3
  } step_t;

  // Operation select carried on op.
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // 20 ms at the 50 MHz kit clock.
  localparam int DEBOUNCE_DEFAULT = 1_000_000;

  // Counter width able to hold the value n without wrapping.
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Push-button conditioner: 2-flop synchronizer, saturating debounce
// counter and press detector. Emits a one-cycle pulse when the accepted
// level falls. A key already held when reset is released never pulses
// until it has been seen released after reset.
module key_debounce
  import addsub_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic pressed
);

  localparam int                CNT_W   = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);

  logic             sync1_r;
  logic             sync2_r;
  logic             level_r;
  logic [CNT_W-1:0] cnt_r;
  logic [1:0]       fill_r;
  logic             armed_r;
  logic             pressed_r;

  logic [CNT_W-1:0] cnt_nx_s;
  logic             level_nx_s;
  logic             accept_s;
  logic             primed_s;

  // Bring the raw key into the clk domain.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
    end else begin
      sync1_r <= key_n;
      sync2_r <= sync1_r;
    end
  end

  // Count consecutive mismatches; accept the new level once the count is full.
  always_comb begin
    cnt_nx_s   = cnt_r;
    level_nx_s = level_r;
    accept_s   = 1'b0;
    if (sync2_r == level_r) begin
      cnt_nx_s = '0;
    end else if (cnt_r >= CNT_MAX) begin
      level_nx_s = sync2_r;
      cnt_nx_s   = '0;
      accept_s   = 1'b1;
    end else begin
      cnt_nx_s = cnt_r + CNT_ONE;
    end
  end

  // Accepted level and its mismatch counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      level_r <= 1'b1;
      cnt_r   <= '0;
    end else begin
      level_r <= level_nx_s;
      cnt_r   <= cnt_nx_s;
    end
  end

  // The synchronizer holds reset values for two cycles; only trust it after that.
  assign primed_s = (fill_r == 2'd2);

  // Track synchronizer fill and arm the detector once a real release is seen.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fill_r  <= 2'd0;
      armed_r <= 1'b0;
    end else begin
      if (!primed_s) begin
        fill_r <= fill_r + 2'd1;
      end else begin
        fill_r <= fill_r;
      end
      armed_r <= armed_r | (primed_s & sync2_r & level_r);
    end
  end

  // One-cycle pulse on an accepted fall of an armed key.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pressed_r <= 1'b0;
    end else begin
      pressed_r <= accept_s & ~sync2_r & armed_r;
    end
  end

  assign pressed = pressed_r;

endmodule

// File: rtl/operand_loader.sv
// Operand entry stage: collects x, y and op one step at a time from the
// slide switches, advanced with the enter key and stepped back with the
// back key. Captured values stay stable for the datapath until overwritten.
module operand_loader
  import addsub_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] sw_data,
  input  logic       key_enter_n,
  input  logic       key_back_n,
  output logic [3:0] x,
  output logic [3:0] y,
  output logic       op,
  output logic       valid,
  output logic [1:0] step
);

  logic       enter_s;
  logic       back_s;
  logic       advance_s;

  step_t      state_r;
  step_t      state_nx_s;
  logic [3:0] x_r;
  logic [3:0] y_r;
  logic       op_r;
  logic       valid_r;
  logic [3:0] x_nx_s;
  logic [3:0] y_nx_s;
  logic       op_nx_s;
  logic       valid_nx_s;

  key_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_enter (
    .clk     (clk),
    .rst_n   (rst_n),
    .key_n   (key_enter_n),
    .pressed (enter_s)
  );

  key_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_back (
    .clk     (clk),
    .rst_n   (rst_n),
    .key_n   (key_back_n),
    .pressed (back_s)
  );

  // Back has priority: a coincident enter is dropped.
  assign advance_s = enter_s & ~back_s;

  // Next step and capture values; anything not written holds.
  always_comb begin
    state_nx_s = state_r;
    x_nx_s     = x_r;
    y_nx_s     = y_r;
    op_nx_s    = op_r;
    valid_nx_s = valid_r;
    case (state_r)
      S_GET_X: begin
        if (advance_s) begin
          x_nx_s     = sw_data;
          state_nx_s = S_GET_Y;
        end else begin
          state_nx_s = S_GET_X;
        end
      end
      S_GET_Y: begin
        if (back_s) begin
          state_nx_s = S_GET_X;
        end else if (advance_s) begin
          y_nx_s     = sw_data;
          state_nx_s = S_GET_OP;
        end else begin
          state_nx_s = S_GET_Y;
        end
      end
      S_GET_OP: begin
        if (back_s) begin
          state_nx_s = S_GET_Y;
        end else if (advance_s) begin
          op_nx_s    = sw_data[0];
          valid_nx_s = 1'b1;
          state_nx_s = S_DONE;
        end else begin
          state_nx_s = S_GET_OP;
        end
      end
      S_DONE: begin
        if (back_s) begin
          valid_nx_s = 1'b0;
          state_nx_s = S_GET_OP;
        end else if (advance_s) begin
          valid_nx_s = 1'b0;
          state_nx_s = S_GET_X;
        end else begin
          state_nx_s = S_DONE;
        end
      end
      default: begin
        valid_nx_s = 1'b0;
        state_nx_s = S_GET_X;
      end
    endcase
  end

  // Step register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= S_GET_X;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Captured operands and the complete-set flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x_r     <= 4'h0;
      y_r     <= 4'h0;
      op_r    <= OP_ADD;
      valid_r <= 1'b0;
    end else begin
      x_r     <= x_nx_s;
      y_r     <= y_nx_s;
      op_r    <= op_nx_s;
      valid_r <= valid_nx_s;
    end
  end

  assign x     = x_r;
  assign y     = y_r;
  assign op    = op_r;
  assign valid = valid_r;
  assign step  = state_r;

endmodule

// File: tb/tb_operand_loader.sv
// Bench for operand_loader with a short debounce window. A reference model
// built from the key-timing and step rules predicts every output each cycle.
module tb_operand_loader;

  localparam int D    = 4;
  localparam int HMAX = 8192;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] sw_data;
  logic       key_enter_n;
  logic       key_back_n;
  logic [3:0] x;
  logic [3:0] y;
  logic       op;
  logic       valid;
  logic [1:0] step;

  int vectors    = 0;
  int miscompares = 0;

  // Reference model state
  logic [3:0] m_x, m_y;
  logic       m_op, m_valid;
  int         m_step;
  bit         hist [2][0:HMAX-1];
  int         hn [2];
  bit         lvl [2];
  bit         arm [2];
  bit         pulse [2];

  operand_loader #(.DEBOUNCE_CYCLES(D)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sw_data     (sw_data),
    .key_enter_n (key_enter_n),
    .key_back_n  (key_back_n),
    .x           (x),
    .y           (y),
    .op          (op),
    .valid       (valid),
    .step        (step)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Synchronized key value seen at history index j (reset value before any sample).
  function automatic bit samp(input int k, input int j);
    if (j < 0) return 1'b1;
    return hist[k][j];
  endfunction

  // Advance the model by one rising edge using the inputs present at that edge.
  task automatic model_step();
    bit en, bk, raw, all_diff, old_arm;
    int n;
    if (!rst_n) begin
      m_x = 4'h0; m_y = 4'h0; m_op = 1'b0; m_valid = 1'b0; m_step = 0;
      for (int k = 0; k < 2; k++) begin
        hn[k] = 0; lvl[k] = 1'b1; arm[k] = 1'b0; pulse[k] = 1'b0;
      end
    end else begin
      bk = pulse[1];
      en = pulse[0] && !pulse[1];
      case (m_step)
        0: if (en) begin m_x = sw_data; m_step = 1; end
        1: if (bk) m_step = 0;
           else if (en) begin m_y = sw_data; m_step = 2; end
        2: if (bk) m_step = 1;
           else if (en) begin m_op = sw_data[0]; m_valid = 1'b1; m_step = 3; end
        3: if (bk) begin m_valid = 1'b0; m_step = 2; end
           else if (en) begin m_valid = 1'b0; m_step = 0; end
        default: m_step = 0;
      endcase
      for (int k = 0; k < 2; k++) begin
        raw = (k == 0) ? key_enter_n : key_back_n;
        if (hn[k] < HMAX) begin
          hist[k][hn[k]] = raw;
          hn[k]++;
        end
        n = hn[k];
        old_arm = arm[k];
        all_diff = 1'b1;
        for (int i = 0; i <= D; i++) begin
          if (samp(k, n - 3 - i) == lvl[k]) all_diff = 1'b0;
        end
        pulse[k] = 1'b0;
        if (all_diff) begin
          lvl[k] = !lvl[k];
          pulse[k] = (lvl[k] == 1'b0) && old_arm;
        end else if ((n - 3 >= 0) && samp(k, n - 3) && lvl[k]) begin
          arm[k] = 1'b1;
        end
      end
    end
  endtask

  task automatic cyc(input int cnt);
    repeat (cnt) begin
      @(posedge clk);
      model_step();
      @(negedge clk);
      chk("x", x, m_x);
      chk("y", y, m_y);
      chk("op", {3'b000, op}, {3'b000, m_op});
      chk("valid", {3'b000, valid}, {3'b000, m_valid});
      chk("step", {2'b00, step}, 4'(m_step));
    end
  endtask

  task automatic press(input bit e, input bit b, input int hold, input int gap);
    key_enter_n = ~e;
    key_back_n  = ~b;
    cyc(hold);
    key_enter_n = 1'b1;
    key_back_n  = 1'b1;
    cyc(gap);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    cyc(2);
  endtask

  initial begin
    int r;
    rst_n = 1'b0; key_enter_n = 1'b1; key_back_n = 1'b1; sw_data = 4'h0;
    for (int k = 0; k < 2; k++) begin
      hn[k] = 0; lvl[k] = 1'b1; arm[k] = 1'b0; pulse[k] = 1'b0;
    end
    m_x = 4'h0; m_y = 4'h0; m_op = 1'b0; m_valid = 1'b0; m_step = 0;

    // Reset state
    cyc(2);
    rst_n = 1'b1;
    cyc(1);
    chk("rst_x", x, 4'h0);
    chk("rst_y", y, 4'h0);
    chk("rst_op", {3'b000, op}, 4'h0);
    chk("rst_valid", {3'b000, valid}, 4'h0);
    chk("rst_step", {2'b00, step}, 4'h0);

    // Held enter: one pulse 7 cycles after the fall, capture one cycle later
    sw_data = 4'h5;
    key_enter_n = 1'b0;
    cyc(7);
    chk("lat_before", {2'b00, step}, 4'h0);
    cyc(1);
    chk("lat_step", {2'b00, step}, 4'h1);
    chk("lat_x", x, 4'h5);
    cyc(2);
    key_enter_n = 1'b1;
    cyc(10);
    chk("held_once", {2'b00, step}, 4'h1);

    // Full entry
    do_reset();
    sw_data = 4'h3; press(1'b1, 1'b0, 10, 10);
    sw_data = 4'h9; press(1'b1, 1'b0, 10, 10);
    sw_data = 4'h1; press(1'b1, 1'b0, 10, 10);
    chk("full_x", x, 4'h3);
    chk("full_y", y, 4'h9);
    chk("full_op", {3'b000, op}, 4'h1);
    chk("full_valid", {3'b000, valid}, 4'h1);
    chk("full_step", {2'b00, step}, 4'h3);
    sw_data = 4'h7; press(1'b1, 1'b0, 10, 10);
    chk("done_valid", {3'b000, valid}, 4'h0);
    chk("done_step", {2'b00, step}, 4'h0);
    chk("done_x", x, 4'h3);
    chk("done_y", y, 4'h9);
    chk("done_op", {3'b000, op}, 4'h1);

    // Bounce shorter than the window
    for (int i = 0; i < 5; i++) begin
      sw_data = 4'($urandom);
      press(1'b1, 1'b0, 3, 3);
    end
    cyc(10);
    chk("bounce_step", {2'b00, step}, 4'h0);
    chk("bounce_x", x, 4'h3);

    // Back navigation from GET_OP
    sw_data = 4'hA; press(1'b1, 1'b0, 10, 10);
    sw_data = 4'h6; press(1'b1, 1'b0, 10, 10);
    chk("op_step", {2'b00, step}, 4'h2);
    press(1'b0, 1'b1, 10, 10);
    chk("back1_step", {2'b00, step}, 4'h1);
    chk("back1_valid", {3'b000, valid}, 4'h0);
    press(1'b0, 1'b1, 10, 10);
    press(1'b0, 1'b1, 10, 10);
    cyc(5);
    chk("back3_step", {2'b00, step}, 4'h0);
    chk("back3_x", x, 4'hA);

    // Coincident enter and back in GET_Y
    sw_data = 4'h2; press(1'b1, 1'b0, 10, 10);
    chk("gety_step", {2'b00, step}, 4'h1);
    sw_data = 4'hF; press(1'b1, 1'b1, 10, 10);
    chk("both_step", {2'b00, step}, 4'h0);
    chk("both_y", y, 4'h6);

    // Reset in DONE with enter held through it
    sw_data = 4'h8; press(1'b1, 1'b0, 10, 10);
    sw_data = 4'h4; press(1'b1, 1'b0, 10, 10);
    sw_data = 4'h1; press(1'b1, 1'b0, 10, 10);
    chk("pre_rst_valid", {3'b000, valid}, 4'h1);
    key_enter_n = 1'b0;
    cyc(1);
    rst_n = 1'b0;
    cyc(1);
    rst_n = 1'b1;
    chk("mid_rst_x", x, 4'h0);
    chk("mid_rst_y", y, 4'h0);
    chk("mid_rst_op", {3'b000, op}, 4'h0);
    chk("mid_rst_valid", {3'b000, valid}, 4'h0);
    chk("mid_rst_step", {2'b00, step}, 4'h0);
    cyc(15);
    chk("held_rst_step", {2'b00, step}, 4'h0);
    key_enter_n = 1'b1;
    cyc(10);
    sw_data = 4'hC; press(1'b1, 1'b0, 10, 10);
    chk("rearm_step", {2'b00, step}, 4'h1);
    chk("rearm_x", x, 4'hC);

    // Randomized presses, bounces and back/enter mixes
    for (int i = 0; i < 40; i++) begin
      r = int'($urandom_range(0, 9));
      sw_data = 4'($urandom);
      if (r < 6)      press(1'b1, 1'b0, int'($urandom_range(1, 14)), int'($urandom_range(8, 14)));
      else if (r < 9) press(1'b0, 1'b1, int'($urandom_range(1, 14)), int'($urandom_range(8, 14)));
      else            press(1'b1, 1'b1, int'($urandom_range(1, 14)), int'($urandom_range(8, 14)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/operand_loader.md
# operand_loader

Upstream input stage for the 4-bit adder/subtractor lab. It lets the user enter x, y and the operation one at a time from four slide switches, confirming each step with debounced push-buttons, and holds the captured operands stable for the `addsub4bits` datapath and display top. It replaces direct switch-to-operand wiring so the kit can run with fewer switches and give glitch-free operand updates.

## Interface
- `DEBOUNCE_CYCLES`, 1_000_000: consecutive synchronized cycles a key must hold a new level before it is accepted (20 ms at 50 MHz).
- `clk`  in  1  system clock, 50 MHz kit clock.
- `rst_n`  in  1  synchronous reset, active-low; sampled on the rising edge of `clk`.
- `sw_data`  in  4  raw slide switches carrying the value for the current step; only bit 0 is used in the op step.
- `key_enter_n`  in  1  raw push-button, active-low (pressed = 0), asynchronous to `clk`.
- `key_back_n`  in  1  raw push-button, active-low, asynchronous to `clk`.
- `x`  out  4  captured first operand.
- `y`  out  4  captured second operand.
- `op`  out  1  captured operation: 0 = add, 1 = subtract.
- `valid`  out  1  high while x, y and op are a complete, confirmed set.
- `step`  out  2  current FSM state, for LEDR/HEX prompting.

## Operation
- Each key passes through a 2-flop synchronizer, then a debouncer.
- Debouncer:
  - Counter clears whenever the synchronized level equals the debounced level.
  - When the counter reaches `DEBOUNCE_CYCLES` consecutive mismatching cycles, the debounced level takes the new value and the counter clears.
  - A falling debounced level produces a one-cycle press pulse. A release produces no pulse.
- FSM states and encodings on `step`:
  - GET_X (0): on enter, x <= sw_data, go to GET_Y.
  - GET_Y (1): on enter, y <= sw_data, go to GET_OP. On back, go to GET_X; x is kept.
  - GET_OP (2): on enter, op <= sw_data[0], valid <= 1, go to DONE. On back, go to GET_Y.
  - DONE (3): on enter, valid <= 0, go to GET_X; x, y and op are kept until overwritten. On back, valid <= 0, go to GET_OP.
- Back in GET_X is ignored.
- Enter and back pulses in the same cycle: back wins and enter is discarded.
- Registers not written in a state hold their value. sw_data changes never affect the outputs except on an enter pulse.
- A key held down yields exactly one pulse. A bounce shorter than `DEBOUNCE_CYCLES` yields none.

## Timing
- Reset (rst_n = 0 at a clk edge) forces on the next cycle:
  - x = 0, y = 0, op = 0, valid = 0, step = GET_X.
  - Debounced levels = 1 (released), counters = 0, synchronizers = 1.
- Reset mid-entry discards the partial entry. No pulse is generated for a key that is already held through reset release until it is released and pressed again.
- Latency from raw key fall, stable, to the press pulse: 2 (synchronizer) + `DEBOUNCE_CYCLES` + 1 cycles.
- Captured register and `step` update on the edge ending the pulse cycle, so they are visible one cycle later.
- Outputs are registered. There is no combinational path from any input to any output.
- Counter width is ceil(log2(`DEBOUNCE_CYCLES`+1)). The counter saturates and never wraps.

## Structure
- Package `addsub_pkg`: 2-bit state constants S_GET_X, S_GET_Y, S_GET_OP, S_DONE, plus OP_ADD = 0 and OP_SUB = 1. The display top shares these for prompts.
- Sub-module `key_debounce`, instantiated twice:
  - Parameter: `DEBOUNCE_CYCLES`.
  - Ports: `clk`, `rst_n`, `key_n`, `pressed` (one-cycle pulse).
  - Contains the synchronizer, counter and edge detector.
- `operand_loader` holds the FSM and the capture registers only.

## Test plan
All scenarios use `DEBOUNCE_CYCLES` = 4.
- Reset, then hold enter low 10 cycles with sw_data = 4'h5:
  - One pulse 7 cycles after the fall.
  - x = 5 and step = 1 on the following cycle.
  - No second pulse while the key is held.
- Full entry: sw_data 3 then 9 then 1, each confirmed with enter:
  - x = 3, y = 9, op = 1, valid = 1, step = 3.
  - Next enter gives valid = 0, step = 0, and x, y, op unchanged.
- Bounce: enter toggles low for 3 cycles, then high, repeated 5 times -> no pulse, step stays 0.
- From GET_OP press back -> step = 1, valid = 0. Press back twice more -> step = 0 and stays 0.
- Enter and back pulses aligned in the same cycle in GET_Y -> step = 0, y unchanged.
- In DONE with valid = 1, assert rst_n = 0 for one cycle -> next cycle x = y = op = valid = 0, step = 0. Enter held through the reset produces no pulse.
